// File: rtl/ship_cfg_pkg.sv
// Shared constants, types and packing helpers for the ship configuration sequencer.
package ship_cfg_pkg;

  localparam int unsigned NUM_SHIPS = 5;
  localparam int unsigned BOARD_DIM = 10;
  localparam int unsigned POS_W     = 7;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PAD_W     = 10;

  localparam int unsigned SHIP_LEN [NUM_SHIPS] = '{5, 4, 3, 3, 2};

  localparam logic [SLOT_W-1:0] SLOT_NONE = 3'b111;

  typedef enum logic [1:0] {
    ERR_BAD_SLOT  = 2'd0,
    ERR_POS_RANGE = 2'd1,
    ERR_NO_FIT    = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALF,
    ST_EMIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic              vert;
    logic [SLOT_W-1:0] slot;
  } ship_half_t;

  localparam ship_half_t HALF_NONE = '{pos: '0, vert: 1'b0, slot: SLOT_NONE};

  // Ship length for a slot; zero for slots outside the bank.
  function automatic int unsigned ship_len(input logic [SLOT_W-1:0] slot);
    if (32'(slot) < NUM_SHIPS) return SHIP_LEN[slot];
    return 0;
  endfunction

  // Half A lands in the upper bits, half B below it, low bits zero.
  function automatic logic [DATA_W-1:0] pack_word(input ship_half_t a, input ship_half_t b);
    return {a, b, {PAD_W{1'b0}}};
  endfunction

  // One-hot mask bit for a slot; empty for the unused-slot marker.
  function automatic logic [NUM_SHIPS-1:0] slot_bit(input logic [SLOT_W-1:0] slot);
    logic [NUM_SHIPS-1:0] m;
    m = '0;
    if (32'(slot) < NUM_SHIPS) m[slot] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ship_cfg_sequencer_if.sv
// Placement request / bank write bus between the MMIO side and the ship sequencer.
interface ship_cfg_sequencer_if;
  import ship_cfg_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [SLOT_W-1:0]    req_slot;
  logic [POS_W-1:0]     req_pos;
  logic                 req_vert;
  logic                 commit;
  logic [DATA_W-1:0]    ship_data;
  logic                 enable;
  logic [NUM_SHIPS-1:0] loaded_mask;
  logic                 err;
  logic [1:0]           err_code;
  logic                 done;

  modport master (
    output req_valid, req_slot, req_pos, req_vert, commit,
    input  req_ready, ship_data, enable, loaded_mask, err, err_code, done
  );

  modport slave (
    input  req_valid, req_slot, req_pos, req_vert, commit,
    output req_ready, ship_data, enable, loaded_mask, err, err_code, done
  );

endinterface

// File: rtl/ship_fit_check.sv
// Combinational placement validator: slot range, position range and board fit.
// Board-edge fit is only enforced when SHIP_CFG_FIT_CHECK_EN is defined.
module ship_fit_check
  import ship_cfg_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic [POS_W-1:0]  pos,
  input  logic              vert,
  output logic              ok,
  output err_code_e         code
);

`ifdef SHIP_CFG_FIT_CHECK_EN
  localparam bit FIT_EN = 1'b1;
`else
  localparam bit FIT_EN = 1'b0;
`endif

  // pos/10 as (pos*205)>>11, exact for every 7-bit position
  localparam int unsigned DIV_MUL   = 205;
  localparam int unsigned DIV_SHIFT = 11;

  logic [15:0]  prod;
  logic [3:0]   row;
  logic [3:0]   col;
  int unsigned  len;
  int unsigned  extent;
  logic         fits;

  always_comb begin
    prod   = 16'(pos) * 16'(DIV_MUL);
    row    = 4'(prod >> DIV_SHIFT);
    col    = 4'(pos - 7'(32'(row) * BOARD_DIM));
    len    = ship_len(slot);
    extent = (vert ? 32'(row) : 32'(col)) + len;
    fits   = (extent <= BOARD_DIM);
  end

  // First failing check wins.
  always_comb begin
    ok   = 1'b0;
    code = ERR_BAD_SLOT;
    if (32'(slot) >= NUM_SHIPS) begin
      code = ERR_BAD_SLOT;
    end else if (32'(pos) >= BOARD_DIM * BOARD_DIM) begin
      code = ERR_POS_RANGE;
    end else if (FIT_EN && !fits) begin
      code = ERR_NO_FIT;
    end else begin
      ok = 1'b1;
    end
  end

endmodule

// File: rtl/ship_cfg_sequencer.sv
// Ship register bank front end: validates placements, pairs them into bank words,
// strobes them into the bank and reports commit completion.
module ship_cfg_sequencer
  import ship_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ship_cfg_sequencer_if.slave  bus
);

  state_e               state_q, state_d;
  ship_half_t           half_q, half_d;
  logic                 flush_q, flush_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 enable_q, enable_d;
  logic                 err_q, err_d;
  err_code_e            code_q, code_d;
  logic                 done_q, done_d;
  logic [NUM_SHIPS-1:0] mask_q, mask_d;
  logic                 ready_q, ready_d;

  logic                 chk_ok;
  err_code_e            chk_code;
  logic                 accept;
  ship_half_t           new_half;

  ship_fit_check u_fit (
    .slot (bus.req_slot),
    .pos  (bus.req_pos),
    .vert (bus.req_vert),
    .ok   (chk_ok),
    .code (chk_code)
  );

  assign accept   = bus.req_valid && ready_q;
  assign new_half = '{pos: bus.req_pos, vert: bus.req_vert, slot: bus.req_slot};

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    flush_d  = flush_q;
    data_d   = data_q;
    code_d   = code_q;
    mask_d   = mask_q;
    enable_d = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && chk_ok) begin
          half_d  = new_half;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (accept && chk_ok) begin
          if (new_half.slot == half_q.slot) begin
            half_d = new_half;
          end else begin
            data_d   = pack_word(half_q, new_half);
            mask_d   = mask_q | slot_bit(half_q.slot) | slot_bit(new_half.slot);
            enable_d = 1'b1;
            flush_d  = 1'b0;
            state_d  = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        state_d = flush_q ? ST_DONE : ST_IDLE;
        done_d  = flush_q;
        flush_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept && !chk_ok) begin
      err_d  = 1'b1;
      code_d = chk_code;
    end

    // Commit acts on the state left by any same-cycle request.
    if (bus.commit) begin
      if (state_d == ST_HALF) begin
        data_d   = pack_word(half_d, HALF_NONE);
        mask_d   = mask_q | slot_bit(half_d.slot);
        enable_d = 1'b1;
        flush_d  = 1'b1;
        state_d  = ST_EMIT;
      end else if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      half_q   <= HALF_NONE;
      flush_q  <= 1'b0;
      data_q   <= '0;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_BAD_SLOT;
      done_q   <= 1'b0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      flush_q  <= flush_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      err_q    <= err_d;
      code_q   <= code_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.ship_data   = data_q;
  assign bus.enable      = enable_q;
  assign bus.loaded_mask = mask_q;
  assign bus.err         = err_q;
  assign bus.err_code    = code_q;
  assign bus.done        = done_q;

endmodule

// File: doc/ship_cfg_sequencer.md
Name: ship_cfg_sequencer

Overview:
- Front-end controller for the ship register bank on the accelerator.
- Accepts one ship placement per handshake from the CPU/MMIO side and validates it against the board geometry.
- Packs accepted placements two per 32-bit ship_data word and drives the one-cycle enable strobe that writes them into the bank.
- Tracks which of the 5 ship slots have been loaded and signals completion after a commit.

Parameters:
- NUM_SHIPS, 5, number of ship slots in the bank.
- BOARD_DIM, 10, board edge length; positions are 0..BOARD_DIM*BOARD_DIM-1 in row-major order.
- POS_W, 7, position field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  placement request valid
- req_ready  out  1  sequencer can accept a request this cycle
- req_slot  in  3  ship slot 0..4
- req_pos  in  7  bow position, row*10+col
- req_vert  in  1  1 = vertical (extends +row), 0 = horizontal (extends +col)
- commit  in  1  one-cycle pulse: flush pending half-word, then report done
- ship_data  out  32  packed word to the bank
- enable  out  1  one-cycle write strobe qualifying ship_data
- loaded_mask  out  5  bit i set once slot i has been written to the bank
- err  out  1  one-cycle pulse: request rejected
- err_code  out  2  0 = bad slot, 1 = pos out of range, 2 = does not fit; held until the next err
- done  out  1  one-cycle pulse: commit completed

Behaviour:
- Reset values:
  - ship_data = 32'h0000_0000.
  - enable, err, done = 0.
  - err_code = 0.
  - loaded_mask = 0.
  - req_ready = 1.
  - FSM in IDLE with no pending half.
- Word format:
  - [31:25] posA, [24] vertA, [23:21] slotA.
  - [20:14] posB, [13] vertB, [12:10] slotB.
  - [9:0] = 0.
  - An unused half has slot = 3'b111 and pos/vert = 0; the bank ignores slot >= 5.
- Acceptance: a request is accepted when req_valid && req_ready.
- Validation of each accepted request, checked in order; the first failing check sets err_code:
  - slot < 5, else code 0.
  - pos < 100, else code 1.
  - fit check (code 2): row = pos/10, col = pos%10, len = SHIP_LEN[slot]. Requires col+len <= 10 when horizontal, row+len <= 10 when vertical.
- A rejected request pulses err on the cycle after acceptance and is otherwise dropped; the FSM state is unchanged.
- FSM:
  - IDLE: no pending half. A valid request is stored as half A, then go to HALF.
  - HALF: half A pending.
    - Valid request with a new slot: build the word (A + new as B), go to EMIT.
    - Valid request with slot equal to pending A: replaces A, stay in HALF.
    - commit: build the word with B unused, go to EMIT with flush flag set.
  - EMIT: enable = 1 for exactly one cycle with the registered word; loaded_mask ORs in the written slots; req_ready = 0. Then:
    - go to DONE if the flush flag is set;
    - otherwise go to IDLE.
  - DONE: done = 1 for one cycle, req_ready = 0, then go to IDLE.
- Latency: enable asserts on the cycle after the accepting edge of the pairing request or the commit.
- req_ready is 1 in IDLE and HALF, 0 in EMIT and DONE.
- commit in IDLE: go straight to DONE; no enable.
- commit in EMIT or DONE: ignored.
- commit and an accepted request in the same cycle:
  - the request is processed first;
  - the commit is honoured on the resulting state if that state is HALF;
  - if that state is EMIT, the commit is ignored.
- Reslotting an already-loaded slot is legal; it rewrites the bank, and its mask bit stays 1.
- Reset mid-operation: any pending half is discarded and no enable is issued; all outputs return to their reset values.

Optional Feature:
- Macro: SHIP_CFG_FIT_CHECK_EN.
- Defined: the fit check (err_code 2) is applied as described.
- Undefined: only the slot and pos-range checks run; ships overhanging the board edge are accepted. err_code 2 is never produced.

Decomposition:
- Package ship_cfg_pkg holds:
  - NUM_SHIPS, BOARD_DIM.
  - SHIP_LEN array {5,4,3,3,2} indexed by slot.
  - SLOT_NONE = 3'b111.
  - err_code enum.
  - Packed struct ship_half_t {pos[6:0], vert, slot[2:0]} and the state enum.
- One sub-module: ship_fit_check. Purely combinational; takes slot/pos/vert and returns ok plus err_code, including the divide/modulo-by-10 logic.

Test Plan:
- Reset: hold rst_n = 0 mid-HALF → all outputs at reset values; req_ready = 1; no enable after release.
- Pairing: req (slot0, pos 0, H) then (slot1, pos 10, H) → one enable with ship_data = 32'h0000_0400 | (10<<14); loaded_mask = 5'b00011.
- Flush: (slot4, pos 98, V)? Rejected with err, err_code 2 (row 9 + 2 > 10). Then (slot4, pos 88, V) followed by commit → enable with ship_data = {7'd88, 1'b1, 3'd4, 7'd0, 1'b0, 3'b111, 10'd0}; done pulses the cycle after enable.
- Range: req_pos 100 → err, err_code 1; no enable. req_slot 6 → err, err_code 0; state unchanged.
- Duplicate: (slot2, pos 5) then (slot2, pos 40) then commit → single enable carrying pos 40 in half A.
- Full load: 5 valid placements + commit → 3 enables, loaded_mask = 5'b11111, then one done. Also run with SHIP_CFG_FIT_CHECK_EN undefined: pos 98 V slot4 is accepted.
